// File: rtl/execute_stage_md.sv
// MIPS execute stage: operand forwarding, ALU, shift-add multiplier with HI/LO and EX/MEM register.
// Optional feature macro: EX_OVF_TRAP_EN (signed ADD/SUB overflow suppresses write-back).
module execute_stage_md #(
    parameter int N_BITS     = 32,
    parameter int N_BITS_REG = 5,
    parameter int MUL_CYCLES = N_BITS
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    input  logic [3:0]            i_alu_ctrl,
    input  logic                  i_alu_src,
    input  logic                  i_reg_dst,
    input  logic [N_BITS-1:0]     i_rs_data,
    input  logic [N_BITS-1:0]     i_rt_data,
    input  logic [N_BITS-1:0]     i_imm,
    input  logic [4:0]            i_shamt,
    input  logic [N_BITS_REG-1:0] i_rs,
    input  logic [N_BITS_REG-1:0] i_rt,
    input  logic [N_BITS_REG-1:0] i_rd,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic                  i_mem_to_reg,
    input  logic                  i_reg_write,
    input  logic                  i_branch,
    input  logic [N_BITS-1:0]     i_wb_data,
    input  logic [N_BITS_REG-1:0] i_wb_rd,
    input  logic                  i_wb_reg_write,
    input  logic                  i_hold,
    input  logic                  i_flush,
    output logic                  o_stall,
    output logic [N_BITS-1:0]     o_alu_result,
    output logic [N_BITS-1:0]     o_store_data,
    output logic [N_BITS_REG-1:0] o_dest,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic                  o_mem_to_reg,
    output logic                  o_reg_write,
    output logic                  o_branch,
    output logic                  o_zero,
    output logic                  o_ovf,
    output logic                  o_mul_busy
);
    localparam int CW = $clog2(MUL_CYCLES + 1);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_LUI  = 4'd10;
    localparam logic [3:0] OP_MULT = 4'd11;
    localparam logic [3:0] OP_MFHI = 4'd12;
    localparam logic [3:0] OP_MFLO = 4'd13;

    typedef enum logic {S_IDLE, S_RUN} mul_state_e;

    mul_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2*N_BITS-1:0]   mcand_q, mcand_d, acc_q, acc_d, acc_step;
    logic [N_BITS-1:0]     mplier_q, mplier_d, hi_q, hi_d, lo_q, lo_d;

    logic [N_BITS-1:0]     res_q, sdata_q;
    logic [N_BITS_REG-1:0] dest_q;
    logic                  mr_q, mw_q, m2r_q, rw_q, br_q, zero_q, ovf_q;

    logic [N_BITS-1:0]     fwd_a, fwd_b, op_b, res, sum, diff;
    logic                  ovf, is_md, stall, mul_go;

    // EX/MEM outranks MEM/WB; r0 is hard-wired and never bypassed
    always_comb begin
        fwd_a = i_rs_data;
        if (rw_q && dest_q != '0 && dest_q == i_rs)
            fwd_a = res_q;
        else if (i_wb_reg_write && i_wb_rd != '0 && i_wb_rd == i_rs)
            fwd_a = i_wb_data;
        fwd_b = i_rt_data;
        if (rw_q && dest_q != '0 && dest_q == i_rt)
            fwd_b = res_q;
        else if (i_wb_reg_write && i_wb_rd != '0 && i_wb_rd == i_rt)
            fwd_b = i_wb_data;
    end

    assign op_b = i_alu_src ? i_imm : fwd_b;
    assign sum  = fwd_a + op_b;
    assign diff = fwd_a - op_b;

    always_comb begin
        res = '0;
        case (i_alu_ctrl)
            OP_AND:  res = fwd_a & op_b;
            OP_OR:   res = fwd_a | op_b;
            OP_ADD:  res = sum;
            OP_SUB:  res = diff;
            OP_SLT:  res = {{(N_BITS-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
            OP_NOR:  res = ~(fwd_a | op_b);
            OP_XOR:  res = fwd_a ^ op_b;
            OP_SLL:  res = fwd_b << i_shamt;
            OP_SRL:  res = fwd_b >> i_shamt;
            OP_SRA:  res = $unsigned($signed(fwd_b) >>> i_shamt);
            OP_LUI:  res = i_imm << (N_BITS / 2);
            OP_MFHI: res = hi_q;
            OP_MFLO: res = lo_q;
            default: res = '0;
        endcase
    end

`ifdef EX_OVF_TRAP_EN
    always_comb begin
        ovf = 1'b0;
        if (i_alu_ctrl == OP_ADD)
            ovf = (fwd_a[N_BITS-1] == op_b[N_BITS-1]) && (sum[N_BITS-1] != fwd_a[N_BITS-1]);
        else if (i_alu_ctrl == OP_SUB)
            ovf = (fwd_a[N_BITS-1] != op_b[N_BITS-1]) && (diff[N_BITS-1] != fwd_a[N_BITS-1]);
    end
`else
    assign ovf = 1'b0;
`endif

    assign is_md  = (i_alu_ctrl == OP_MULT) || (i_alu_ctrl == OP_MFHI) || (i_alu_ctrl == OP_MFLO);
    assign stall  = i_valid && ((state_q == S_RUN && is_md) || i_hold);
    assign mul_go = i_valid && state_q == S_IDLE && !stall && i_alu_ctrl == OP_MULT;
    assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (mul_go) begin
                    state_d  = S_RUN;
                    cnt_d    = CW'(MUL_CYCLES);
                    mcand_d  = {{N_BITS{1'b0}}, fwd_a};
                    mplier_d = op_b;
                    acc_d    = '0;
                end
            end
            S_RUN: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d      = S_IDLE;
                    {hi_d, lo_d} = acc_step;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n || i_flush || (!i_hold && (stall || !i_valid))) begin
            res_q   <= '0;
            sdata_q <= '0;
            dest_q  <= '0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            rw_q    <= 1'b0;
            br_q    <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (!i_hold) begin
            res_q   <= res;
            sdata_q <= fwd_b;
            dest_q  <= i_reg_dst ? i_rd : i_rt;
            mr_q    <= i_mem_read;
            mw_q    <= i_mem_write;
            m2r_q   <= i_mem_to_reg;
            rw_q    <= i_reg_write && i_alu_ctrl != OP_MULT && !ovf;
            br_q    <= i_branch;
            zero_q  <= (res == '0);
            ovf_q   <= ovf;
        end
    end

    assign o_stall      = stall;
    assign o_alu_result = res_q;
    assign o_store_data = sdata_q;
    assign o_dest       = dest_q;
    assign o_mem_read   = mr_q;
    assign o_mem_write  = mw_q;
    assign o_mem_to_reg = m2r_q;
    assign o_reg_write  = rw_q;
    assign o_branch     = br_q;
    assign o_zero       = zero_q;
    assign o_ovf        = ovf_q;
    assign o_mul_busy   = (state_q == S_RUN);
endmodule

// File: tb/tb_execute_stage_md.sv
// Randomized bench for execute_stage_md against a behavioural model.
// Honours EX_OVF_TRAP_EN the same way the design does.
module tb_execute_stage_md;
    localparam int N = 32;
    localparam int R = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid, alu_src, reg_dst;
    logic [3:0]   ctrl;
    logic [N-1:0] rs_data, rt_data, imm, wb_data;
    logic [4:0]   shamt;
    logic [R-1:0] rs, rt, rd, wb_rd;
    logic         mr, mw, m2r, rw, br, wb_rw, hold, flush;
    logic         stall, o_mr, o_mw, o_m2r, o_rw, o_br, zero, ovf, busy;
    logic [N-1:0] res, sdata;
    logic [R-1:0] dest;

    execute_stage_md dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .i_alu_ctrl(ctrl),
        .i_alu_src(alu_src), .i_reg_dst(reg_dst), .i_rs_data(rs_data),
        .i_rt_data(rt_data), .i_imm(imm), .i_shamt(shamt), .i_rs(rs), .i_rt(rt),
        .i_rd(rd), .i_mem_read(mr), .i_mem_write(mw), .i_mem_to_reg(m2r),
        .i_reg_write(rw), .i_branch(br), .i_wb_data(wb_data), .i_wb_rd(wb_rd),
        .i_wb_reg_write(wb_rw), .i_hold(hold), .i_flush(flush), .o_stall(stall),
        .o_alu_result(res), .o_store_data(sdata), .o_dest(dest),
        .o_mem_read(o_mr), .o_mem_write(o_mw), .o_mem_to_reg(o_m2r),
        .o_reg_write(o_rw), .o_branch(o_br), .o_zero(zero), .o_ovf(ovf),
        .o_mul_busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model of what EX/MEM should hold, plus HI/LO and remaining multiply cycles
    logic [N-1:0]  e_res, e_sd, m_hi, m_lo;
    logic [R-1:0]  e_dest;
    logic          e_mr, e_mw, e_m2r, e_rw, e_br, e_zero, e_ovf;
    logic [63:0]   m_prod;
    int            m_rem;
    logic          last_st;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_res = '0; e_sd = '0; e_dest = '0;
        {e_mr, e_mw, e_m2r, e_rw, e_br, e_zero, e_ovf} = '0;
        m_hi = '0; m_lo = '0; m_prod = '0; m_rem = 0;
    endtask

    function automatic logic [N-1:0] fwd(input logic [R-1:0] src, input logic [N-1:0] v);
        if (e_rw && e_dest != 0 && e_dest == src) return e_res;
        if (wb_rw && wb_rd != 0 && wb_rd == src) return wb_data;
        return v;
    endfunction

    task automatic nop();
        valid = 0; ctrl = 0; alu_src = 0; reg_dst = 0;
        rs_data = 0; rt_data = 0; imm = 0; shamt = 0;
        rs = 0; rt = 0; rd = 0;
        {mr, mw, m2r, rw, br} = '0;
        wb_data = 0; wb_rd = 0; wb_rw = 0; hold = 0; flush = 0;
    endtask

    task automatic op(input logic [3:0] c, input logic [R-1:0] a_r, input logic [R-1:0] b_r,
                      input logic [N-1:0] a_v, input logic [N-1:0] b_v, input logic [R-1:0] d_r,
                      input logic w);
        nop();
        valid = 1; ctrl = c; rs = a_r; rt = b_r; rs_data = a_v; rt_data = b_v;
        reg_dst = 1; rd = d_r; rw = w;
    endtask

    task automatic step();
        logic [N-1:0] a, b, rtv, r;
        logic         st, ov, go;
        longint       sa, sb, wide;
        #2;
        a   = fwd(rs, rs_data);
        rtv = fwd(rt, rt_data);
        b   = alu_src ? imm : rtv;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        st  = valid && (((ctrl == 11) || (ctrl == 12) || (ctrl == 13)) && m_rem > 0 || hold);
        chk("stall", stall, st);
        last_st = st;
        ov = 0;
        wide = 0;
        case (ctrl)
            0: r = a & b;
            1: r = a | b;
            2: begin r = a + b; wide = sa + sb; end
            3: begin r = a - b; wide = sa - sb; end
            4: r = (sa < sb) ? 1 : 0;
            5: r = ~(a | b);
            6: r = a ^ b;
            7: r = rtv << shamt;
            8: r = rtv >> shamt;
            9: r = N'(longint'($signed(rtv)) >>> shamt);
            10: r = {imm[15:0], 16'h0};
            12: r = m_hi;
            13: r = m_lo;
            default: r = 0;
        endcase
`ifdef EX_OVF_TRAP_EN
        if (ctrl == 2 || ctrl == 3)
            ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
`endif
        go = valid && m_rem == 0 && !st && ctrl == 11;
        @(posedge clk);
        #1;
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) {m_hi, m_lo} = m_prod;
        end
        if (go) begin
            m_prod = 64'(a) * 64'(b);
            m_rem  = 32;
        end
        if (flush || (!hold && (st || !valid))) begin
            e_res = '0; e_sd = '0; e_dest = '0;
            {e_mr, e_mw, e_m2r, e_rw, e_br, e_zero, e_ovf} = '0;
        end else if (!hold) begin
            e_res = r; e_sd = rtv; e_dest = reg_dst ? rd : rt;
            e_mr = mr; e_mw = mw; e_m2r = m2r; e_br = br;
            e_rw = rw && ctrl != 11 && !ov;
            e_zero = (r == 0); e_ovf = ov;
        end
        chk("result", res, e_res);
        chk("store", sdata, e_sd);
        chk("dest", dest, e_dest);
        chk("ctl", {o_mr, o_mw, o_m2r, o_rw, o_br}, {e_mr, e_mw, e_m2r, e_rw, e_br});
        chk("zero", zero, e_zero);
        chk("ovf", ovf, e_ovf);
        chk("busy", busy, m_rem > 0);
    endtask

    initial begin
        int bcnt;
        bit done;
        nop();
        model_reset();
        rst_n = 0;
        #3;
        chk("rst_res", res, 0);
        chk("rst_rw", o_rw, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1;

        // forwarding priority
        op(2, 0, 0, 0, 0, 3, 1); alu_src = 1; imm = 32'h11; step();
        op(2, 3, 0, 32'h99, 0, 5, 0); wb_rd = 3; wb_data = 32'h22; wb_rw = 1; step();
        chk("fwd_exmem", res, 32'h11);
        op(2, 0, 0, 0, 0, 3, 0); alu_src = 1; imm = 32'h11; step();
        op(2, 3, 0, 32'h99, 0, 5, 0); wb_rd = 3; wb_data = 32'h22; wb_rw = 1; step();
        chk("fwd_memwb", res, 32'h22);
        op(2, 0, 0, 32'h33, 0, 5, 0); wb_rd = 0; wb_data = 32'h44; wb_rw = 1; step();
        chk("fwd_r0", res, 32'h33);

        // multiply then MFHI/MFLO
        nop(); step();
        op(11, 1, 2, 32'hFFFF_FFFF, 32'h2, 0, 1); step();
        bcnt = busy;
        done = 0;
        op(12, 0, 0, 0, 0, 6, 1);
        for (int k = 0; k < 40 && !done; k++) begin
            step();
            bcnt += busy;
            if (!last_st) done = 1;
        end
        chk("mfhi_wait", done, 1);
        chk("busy_len", bcnt, 32);
        chk("mfhi", res, 32'h1);
        op(13, 0, 0, 0, 0, 6, 1); step();
        chk("mflo", res, 32'hFFFF_FFFE);

        // independent op during multiply, second MULT stalls
        op(11, 1, 2, 3, 5, 0, 0); step();
        op(2, 1, 2, 5, 7, 4, 1); step();
        chk("add_nostall", last_st, 0);
        chk("add_run", res, 12);
        op(11, 1, 2, 6, 7, 0, 0);
        bcnt = 0;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            step();
            bcnt++;
            if (!last_st) done = 1;
        end
        chk("mult2_wait", done, 1);
        chk("mult2_stalled", bcnt > 1, 1);

        // hold and flush
        op(2, 1, 2, 5, 7, 4, 1); mw = 1; step();
        op(2, 1, 2, 1, 1, 7, 0); hold = 1; step();
        chk("hold_res", res, 12);
        chk("hold_rw", o_rw, 1);
        flush = 1; step();
        chk("flush_rw", o_rw, 0);
        chk("flush_mw", o_mw, 0);

        // reset mid-multiply
        nop();
        for (int k = 0; k < 40 && m_rem > 0; k++) step();
        op(11, 1, 2, 32'h10, 32'h10, 0, 0); step();
        nop();
        for (int k = 0; k < 9; k++) step();
        rst_n = 0;
        #1;
        chk("rst_mid_busy", busy, 0);
        model_reset();
        #1 rst_n = 1;
        op(13, 0, 0, 0, 0, 6, 1); step();
        chk("mflo_after_rst", res, 0);

        // signed overflow boundary
        op(2, 1, 2, 32'h7FFF_FFFF, 32'h1, 8, 1); step();
`ifdef EX_OVF_TRAP_EN
        chk("ovf_flag", ovf, 1);
        chk("ovf_rw", o_rw, 0);
`else
        chk("ovf_wrap", res, 32'h8000_0000);
        chk("ovf_flag", ovf, 0);
`endif

        // random traffic
        for (int k = 0; k < 800; k++) begin
            nop();
            valid   = ($urandom_range(0, 9) != 0);
            ctrl    = ($urandom_range(0, 5) == 0) ? 4'(11 + $urandom_range(0, 2)) : 4'($urandom_range(0, 15));
            alu_src = $urandom_range(0, 1);
            reg_dst = $urandom_range(0, 1);
            rs_data = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + $urandom_range(0, 2) : $urandom;
            rt_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            imm     = $urandom;
            shamt   = 5'($urandom);
            rs = R'($urandom_range(0, 3)); rt = R'($urandom_range(0, 3)); rd = R'($urandom_range(0, 3));
            {mr, mw, m2r, rw, br} = 5'($urandom);
            wb_data = $urandom; wb_rd = R'($urandom_range(0, 3)); wb_rw = $urandom_range(0, 1);
            hold    = ($urandom_range(0, 9) == 0);
            flush   = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/execute_stage_md.md
Name: execute_stage_md

Overview:
- Parametrised successor execute stage for the 5-stage MIPS pipeline, sitting between the ID/EX register and the memory stage.
- Integrates forwarding-select logic and the ALU, fixing the 2-bit forward mux selects.
- Adds an iterative background multiplier with HI/LO registers and stall handshake.
- Owns the EX/MEM pipeline register, with hold and flush.

Parameters:
- N_BITS, 32, datapath width (>=8, even).
- N_BITS_REG, 5, register-address width.
- MUL_CYCLES, N_BITS, multiplier iterations; must equal N_BITS (one bit per cycle).

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  ID/EX holds a real instruction (0 = bubble)
- i_alu_ctrl  in  4  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 NOR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 LUI, 11 MULT, 12 MFHI, 13 MFLO; 14-15 give result 0
- i_alu_src  in  1  1 = operand B from i_imm
- i_reg_dst  in  1  1 = destination rd, 0 = rt
- i_rs_data, i_rt_data, i_imm  in  N_BITS  ID/EX operands, sign-extended immediate
- i_shamt  in  5  shift amount
- i_rs, i_rt, i_rd  in  N_BITS_REG  register addresses
- i_mem_read, i_mem_write, i_mem_to_reg, i_reg_write, i_branch  in  1  control passed to MEM
- i_wb_data  in  N_BITS  MEM/WB write-back value
- i_wb_rd  in  N_BITS_REG  MEM/WB destination
- i_wb_reg_write  in  1  MEM/WB write enable
- i_hold  in  1  downstream hold: EX/MEM keeps its value
- i_flush  in  1  load bubble into EX/MEM
- o_stall  out  1  EX cannot retire this cycle; upstream must hold ID/EX
- o_alu_result, o_store_data  out  N_BITS  EX/MEM registered outputs
- o_dest  out  N_BITS_REG  EX/MEM registered destination
- o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write, o_branch, o_zero, o_ovf  out  1  EX/MEM registered control and flags
- o_mul_busy  out  1  multiplier running

Behaviour:
- Reset (i_reset_n=0, async): all outputs, HI, LO, multiplier state and counter go to 0.
- Forwarding, per operand:
  - Select EX/MEM (o_alu_result) if o_reg_write & o_dest!=0 & o_dest==src.
  - Else select MEM/WB (i_wb_data) if i_wb_reg_write & i_wb_rd!=0 & i_wb_rd==src.
  - Else use the ID/EX value.
  - EX/MEM has priority; register 0 is never forwarded.
- Operand B = i_imm when i_alu_src, else forwarded rt. o_store_data = forwarded rt.
- Arithmetic wraps modulo 2^N_BITS.
  - SLT is signed.
  - Shifts use i_shamt on forwarded rt.
  - LUI = imm << N_BITS/2.
  - o_zero = (result == 0).
- Multiplier FSM: IDLE -> RUN -> IDLE.
  - MULT accepted when i_valid & state IDLE & no stall: latch operands (unsigned); counter = MUL_CYCLES.
  - RUN does one shift-add step per cycle.
  - On the last step, {HI,LO} = full 2*N_BITS product; return to IDLE.
  - HI/LO are readable on the first IDLE cycle, so latency from accept to MFHI/MFLO-usable = MUL_CYCLES+1 cycles.
  - o_mul_busy = (state == RUN).
  - An accepted MULT retires into EX/MEM immediately with o_reg_write=0.
- Stall sources:
  - o_stall = i_valid & state==RUN & i_alu_ctrl in {MULT, MFHI, MFLO}.
  - Other instructions proceed while the multiplier runs.
- EX/MEM update priority:
  - i_flush: load bubble (all control 0, data 0).
  - Else i_hold: keep current value; multiplier keeps running; o_stall additionally asserted when i_valid.
  - Else o_stall or !i_valid: load bubble.
  - Else capture results.
- i_flush does not abort a running multiply. Only reset aborts it; after reset HI=LO=0.

Optional Feature:
- Macro: EX_OVF_TRAP_EN.
- Defined:
  - Signed overflow on ADD/SUB sets o_ovf=1 in EX/MEM.
  - o_reg_write forced 0 for that instruction; the result is still registered.
- Undefined: o_ovf tied 0; ADD/SUB wrap silently.

Test Plan:
- Forward priority: EX/MEM holds dest 3 = 0x11, MEM/WB dest 3 = 0x22 with write enabled, ADD rs=3 rt=0 -> o_alu_result=0x11. With EX/MEM o_reg_write=0 -> 0x22. With rs=0 -> ID/EX value.
- Multiply: MULT 0xFFFFFFFF × 0x2, then MFHI, MFLO.
  - MFHI stalls until state IDLE, then o_alu_result=0x1.
  - MFLO -> 0xFFFFFFFE.
  - o_mul_busy high exactly 32 cycles.
- Independent ops during multiply: ADD 5+7 issued during RUN retires next cycle with o_stall=0 and result 12. A second MULT during RUN stalls until IDLE.
- Hold/flush: i_hold=1 with new inputs -> outputs unchanged. i_flush=1 with i_hold=1 -> bubble (o_reg_write=0, o_mem_write=0).
- Reset mid-multiply: assert i_reset_n=0 at RUN cycle 10 -> o_mul_busy=0 immediately; subsequent MFLO returns 0.
- EX_OVF_TRAP_EN: ADD 0x7FFFFFFF+1.
  - Defined -> o_ovf=1, o_reg_write=0.
  - Undefined -> o_alu_result=0x80000000, o_ovf=0.
